// File: rtl/change_rx_dispense.sv
// Serial change receiver: deserialises an 8-bit magnitude, then pays it out one coin per pulse, largest first.
// Optional framing check enabled by defining CHANGE_RX_FRAME_CHECK_EN.
module change_rx_dispense #(
  parameter int COIN_HI  = 10,
  parameter int COIN_MID = 5,
  parameter int COIN_LO  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_rdy,
  input  logic       ser_data,
  input  logic       ser_done,
  output logic [7:0] value,
  output logic       value_valid,
  output logic       coin_pulse,
  output logic [1:0] coin_sel,
  output logic       busy,
  output logic       dispense_done,
  output logic       overrun,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, DISPENSE} state_t;

  localparam logic [7:0] HI_VAL  = 8'(COIN_HI);
  localparam logic [7:0] MID_VAL = 8'(COIN_MID);
  localparam logic [7:0] LO_VAL  = 8'(COIN_LO);

  state_t     state, state_nxt;
  logic [7:0] sreg, sreg_nxt;
  logic [7:0] remaining, remaining_nxt;
  logic [7:0] value_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] coin_sel_nxt;
  logic       gap, gap_nxt;
  logic       armed, armed_nxt;
  logic       value_valid_nxt, coin_pulse_nxt, busy_nxt;
  logic       dispense_done_nxt, overrun_nxt, frame_err_nxt;
  logic       frame_ok;
  logic       drop_err;

`ifdef CHANGE_RX_FRAME_CHECK_EN
  assign frame_ok = !ser_rdy && ser_done;
  assign drop_err = 1'b1;
`else
  // Without the frame check ser_done carries no meaning and every frame is accepted.
  assign frame_ok = ser_done | 1'b1;
  assign drop_err = 1'b0;
`endif

  always_comb begin
    state_nxt         = state;
    sreg_nxt          = sreg;
    cnt_nxt           = cnt;
    remaining_nxt     = remaining;
    gap_nxt           = gap;
    armed_nxt         = armed;
    value_nxt         = value;
    coin_sel_nxt      = coin_sel;
    busy_nxt          = busy;
    value_valid_nxt   = 1'b0;
    coin_pulse_nxt    = 1'b0;
    dispense_done_nxt = 1'b0;
    overrun_nxt       = 1'b0;
    frame_err_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (!ser_rdy) begin
          armed_nxt = 1'b1;
        end else if (armed) begin
          state_nxt = SHIFT;
          cnt_nxt   = 4'd0;
          busy_nxt  = 1'b1;
        end
      end

      SHIFT: begin
        if (!ser_rdy) begin
          state_nxt     = IDLE;
          busy_nxt      = 1'b0;
          frame_err_nxt = drop_err;
        end else begin
          sreg_nxt = {sreg[6:0], ser_data};
          cnt_nxt  = cnt + 4'd1;
          if (cnt == 4'd7) state_nxt = CHECK;
        end
      end

      CHECK: begin
        if (frame_ok) begin
          value_nxt       = sreg;
          value_valid_nxt = 1'b1;
          remaining_nxt   = sreg;
          gap_nxt         = 1'b0;
          state_nxt       = DISPENSE;
        end else begin
          frame_err_nxt = 1'b1;
          busy_nxt      = 1'b0;
          state_nxt     = IDLE;
        end
      end

      DISPENSE: begin
        // A frame arriving now is dropped; one overrun pulse per frame, and IDLE
        // must see ser_rdy low before it will accept again.
        if (ser_rdy) begin
          overrun_nxt = armed;
          armed_nxt   = 1'b0;
        end else begin
          armed_nxt = 1'b1;
        end

        if (gap) begin
          gap_nxt = 1'b0;
        end else if (remaining == 8'd0) begin
          state_nxt         = IDLE;
          busy_nxt          = 1'b0;
          dispense_done_nxt = 1'b1;
        end else begin
          coin_pulse_nxt = 1'b1;
          gap_nxt        = 1'b1;
          if (remaining >= HI_VAL) begin
            coin_sel_nxt  = 2'd2;
            remaining_nxt = remaining - HI_VAL;
          end else if (remaining >= MID_VAL) begin
            coin_sel_nxt  = 2'd1;
            remaining_nxt = remaining - MID_VAL;
          end else begin
            coin_sel_nxt  = 2'd0;
            remaining_nxt = remaining - LO_VAL;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      sreg          <= 8'd0;
      cnt           <= 4'd0;
      remaining     <= 8'd0;
      gap           <= 1'b0;
      armed         <= 1'b1;
      value         <= 8'd0;
      value_valid   <= 1'b0;
      coin_pulse    <= 1'b0;
      coin_sel      <= 2'd0;
      busy          <= 1'b0;
      dispense_done <= 1'b0;
      overrun       <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      state         <= state_nxt;
      sreg          <= sreg_nxt;
      cnt           <= cnt_nxt;
      remaining     <= remaining_nxt;
      gap           <= gap_nxt;
      armed         <= armed_nxt;
      value         <= value_nxt;
      value_valid   <= value_valid_nxt;
      coin_pulse    <= coin_pulse_nxt;
      coin_sel      <= coin_sel_nxt;
      busy          <= busy_nxt;
      dispense_done <= dispense_done_nxt;
      overrun       <= overrun_nxt;
      frame_err     <= frame_err_nxt;
    end
  end

endmodule

// File: tb/tb_change_rx_dispense.sv
// Directed bench for change_rx_dispense: frame reception, coin payout order, overrun, framing and reset.
module tb_change_rx_dispense;

  logic       clk = 1'b0;
  logic       rst, ser_rdy, ser_data, ser_done;
  logic [7:0] value;
  logic       value_valid, coin_pulse, busy, dispense_done, overrun, frame_err;
  logic [1:0] coin_sel;

`ifdef CHANGE_RX_FRAME_CHECK_EN
  localparam int ERR = 1;
`else
  localparam int ERR = 0;
`endif

  change_rx_dispense dut (
    .clk(clk), .rst(rst), .ser_rdy(ser_rdy), .ser_data(ser_data), .ser_done(ser_done),
    .value(value), .value_valid(value_valid), .coin_pulse(coin_pulse), .coin_sel(coin_sel),
    .busy(busy), .dispense_done(dispense_done), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] coins[$];
  int         coin_cyc[$];
  int         vv_n = 0, vv_cyc = 0, dd_n = 0, dd_cyc = 0, ov_n = 0, fe_n = 0, busy_low = 0;
  logic [7:0] vv_val = 8'd0;
  bit         watch_busy = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (coin_pulse) begin
        coins.push_back(coin_sel);
        coin_cyc.push_back(cyc);
      end
      if (value_valid) begin
        vv_n++;
        vv_cyc = cyc;
        vv_val = value;
      end
      if (dispense_done) begin
        dd_n++;
        dd_cyc = cyc;
      end
      if (overrun) ov_n++;
      if (frame_err) fe_n++;
      if (watch_busy && !busy && !dispense_done) busy_low++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // e0 is the cycle number of the edge that first samples ser_rdy high.
  task automatic send(input logic [7:0] v, input int nbits, input bit done, output int e0);
    @(posedge clk); #1;
    ser_rdy = 1'b1; ser_data = 1'b0; e0 = cyc + 1;
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1;
      ser_data = v[7-i];
    end
    @(posedge clk); #1;
    ser_rdy = 1'b0; ser_data = 1'b0; ser_done = done;
    @(posedge clk); #1;
    ser_done = 1'b0;
  endtask

  task automatic wait_dd(input int base, input string tag);
    int n = 0;
    while (dd_n == base && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check(tag, 32'(dd_n > base), 1);
  endtask

  task automatic wait_coins(input int target);
    int n = 0;
    while (coins.size() < target && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
  endtask

  task automatic check_coins(input string tag, input int base, input int n, input logic [15:0] seq);
    check({tag, "_ncoins"}, coins.size() - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < coins.size()) check({tag, "_sel"}, 32'(coins[base+i]), 32'(seq[2*i +: 2]));
      if (i > 0 && base + i < coins.size())
        check({tag, "_spacing"}, coin_cyc[base+i] - coin_cyc[base+i-1], 2);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 32'({value, value_valid, coin_pulse, coin_sel, busy, dispense_done, overrun, frame_err}), 0);
  endtask

  initial begin
    int e0, e1, cb, db, vb, ob, fb, hi, mid, lo;
    rst = 1'b1; ser_rdy = 1'b0; ser_data = 1'b0; ser_done = 1'b0;
    #12;
    check_all_zero("reset_outputs");
    @(posedge clk); #1; rst = 1'b0;

    // 37 = 10+10+10+5+1+1
    cb = coins.size(); db = dd_n; vb = vv_n;
    send(8'd37, 8, 1'b1, e0);
    wait_dd(db, "t37_done");
    check("t37_vv_count", vv_n - vb, 1);
    check("t37_value", 32'(vv_val), 37);
    check("t37_vv_latency", vv_cyc, e0 + 9);
    check_coins("t37", cb, 6, {2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2});
    check("t37_done_cycle", dd_cyc, (coins.size() >= cb + 6) ? coin_cyc[cb+5] + 2 : -1);
    check("t37_busy_after", 32'(busy), 0);
    check("t37_value_hold", 32'(value), 37);

    // zero change: done one cycle after value_valid, no coins
    cb = coins.size(); db = dd_n;
    send(8'd0, 8, 1'b1, e0);
    wait_dd(db, "t0_done");
    check("t0_value", 32'(vv_val), 0);
    check("t0_done_cycle", dd_cyc, vv_cyc + 1);
    check("t0_ncoins", coins.size() - cb, 0);

    // 128 = 12x10 + 5 + 3x1, busy held throughout
    cb = coins.size(); db = dd_n; busy_low = 0;
    send(8'd128, 8, 1'b1, e0);
    watch_busy = 1'b1;
    wait_dd(db, "t128_done");
    watch_busy = 1'b0;
    hi = 0; mid = 0; lo = 0;
    for (int i = cb; i < coins.size(); i++) begin
      if (coins[i] == 2'd2) hi++;
      else if (coins[i] == 2'd1) mid++;
      else lo++;
    end
    check("t128_value", 32'(vv_val), 128);
    check("t128_hi", hi, 12);
    check("t128_mid", mid, 1);
    check("t128_lo", lo, 3);
    check("t128_busy_low", busy_low, 0);

    // frame during payout of 37 is dropped; payout unaffected
    cb = coins.size(); db = dd_n; vb = vv_n; ob = ov_n;
    send(8'd37, 8, 1'b1, e0);
    wait_coins(cb + 2);
    send(8'hAA, 8, 1'b1, e1);
    wait_dd(db, "ovr_done");
    check("ovr_seen", 32'(ov_n > ob), 1);
    check("ovr_vv_count", vv_n - vb, 1);
    check("ovr_value", 32'(value), 37);
    check_coins("ovr", cb, 6, {2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2});
    repeat (3) @(negedge clk);
    cb = coins.size(); db = dd_n;
    send(8'd6, 8, 1'b1, e0);
    wait_dd(db, "t6_done");
    check("t6_value", 32'(value), 6);
    check_coins("t6", cb, 2, {12'd0, 2'd0, 2'd1});

    // ser_rdy dropped after 4 bits
    vb = vv_n; fb = fe_n;
    send(8'hF0, 4, 1'b1, e0);
    @(negedge clk); #1;
    check("drop_busy", 32'(busy), 0);
    check("drop_vv", vv_n - vb, 0);
    check("drop_ferr", fe_n - fb, ERR);
    check("drop_value", 32'(value), 6);

    // ser_done withheld at end of frame
    vb = vv_n; fb = fe_n; cb = coins.size(); db = dd_n;
    send(8'd2, 8, 1'b0, e0);
`ifdef CHANGE_RX_FRAME_CHECK_EN
    repeat (2) @(negedge clk); #1;
    check("nodone_ferr", fe_n - fb, 1);
    check("nodone_vv", vv_n - vb, 0);
    check("nodone_value", 32'(value), 6);
    check("nodone_busy", 32'(busy), 0);
`else
    wait_dd(db, "nodone_done");
    check("nodone_vv", vv_n - vb, 1);
    check("nodone_value", 32'(value), 2);
    check_coins("nodone", cb, 2, {12'd0, 2'd0, 2'd0});
    check("no_ferr_total", fe_n, 0);
`endif

    // reset mid-SHIFT
    @(posedge clk); #1; ser_rdy = 1'b1;
    repeat (4) begin
      @(posedge clk); #1; ser_data = 1'b1;
    end
    check("midshift_busy", 32'(busy), 1);
    rst = 1'b1; #1;
    check_all_zero("midshift_reset");
    ser_rdy = 1'b0; ser_data = 1'b0;
    @(posedge clk); #1; rst = 1'b0;

    // reset mid-DISPENSE
    cb = coins.size();
    send(8'd37, 8, 1'b1, e0);
    wait_coins(cb + 1);
    check("middisp_busy", 32'(busy), 1);
    rst = 1'b1; #1;
    check_all_zero("middisp_reset");
    @(posedge clk); #1; rst = 1'b0;

    cb = coins.size(); db = dd_n;
    send(8'd15, 8, 1'b1, e0);
    wait_dd(db, "t15_done");
    check("t15_value", 32'(value), 15);
    check_coins("t15", cb, 2, {12'd0, 2'd1, 2'd2});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
